// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared CPU-side types and constants used by the data-memory responder.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam int WORD_W       = 32;
  localparam int DMEM_LAT_MAX = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

endpackage

`default_nettype wire

// File: rtl/sram_1rw.sv
// ---------------------------------------------------------------------------
// sram_1rw
// Single-port word array: synchronous write, registered read.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_1rw
  import cpu_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [WORD_W-1:0]     i_wdata,
  output logic [WORD_W-1:0]     o_rdata
);

  // Backing store; the name is kept stable so benches can peek at it.
  logic [WORD_W-1:0] memory [0:(1<<DEPTH_LOG2)-1];
  logic [WORD_W-1:0] r_rdata;

  // Write port: store data lands on the edge where write enable is high.
  always_ff @(posedge clk) begin
    if (i_we) begin
      memory[i_addr] <= i_wdata;
    end
  end

  // Read port: registered, returns the pre-write contents on a collision.
  always_ff @(posedge clk) begin
    r_rdata <= memory[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Memory-side end of the MEM-stage data interface: services one load/store
// at a time with a fixed multi-cycle latency, stalling the pipeline until
// the access completes.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_responder
  import cpu_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [31:0]       addr_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [WORD_W-1:0] data_o,
  output logic              stall_o,
  output logic              done_o
);

  // Counter preload: LATENCY BUSY cycles in total, counting down to zero.
  localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);

  dmem_state_t           r_state;
  logic [3:0]            r_count;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic                  r_is_load;
  logic [WORD_W-1:0]     r_data;

  logic                  w_req;
  logic [DEPTH_LOG2-1:0] w_word_idx;
  logic [DEPTH_LOG2-1:0] w_sram_addr;
  logic                  w_we;
  logic [WORD_W-1:0]     w_rdata;
  logic                  w_unused_addr;

  // Reset masks the request so nothing is accepted (or stalled on) while
  // reset is asserted.
  assign w_req         = (MemRead_i | MemWrite_i) & ~rst_i;
  assign w_word_idx    = addr_i[DEPTH_LOG2+1:2];
  assign w_unused_addr = ^{addr_i[31:DEPTH_LOG2+2], addr_i[1:0]};

  // In IDLE the array is addressed straight from the request so the
  // registered read is already valid by the first BUSY cycle; afterwards
  // the latched index keeps it stable regardless of input changes.
  assign w_sram_addr = (r_state == IDLE) ? w_word_idx : r_idx;

  // Stores (including read+write collisions) commit on the accept edge.
  assign w_we = (r_state == IDLE) & MemWrite_i & ~rst_i;

  sram_1rw #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_sram (
    .clk     (clk_i),
    .i_we    (w_we),
    .i_addr  (w_sram_addr),
    .i_wdata (data_i),
    .o_rdata (w_rdata)
  );

  // Access FSM: accept in IDLE, count down in BUSY, pulse completion in DONE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_count   <= 4'd0;
      r_data    <= '0;
      r_idx     <= '0;
      r_is_load <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_idx     <= w_word_idx;
            r_is_load <= MemRead_i & ~MemWrite_i;
            r_count   <= c_CNT_INIT;
            r_state   <= BUSY;
          end
        end
        BUSY: begin
          if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
          end else begin
            if (r_is_load) begin
              r_data <= w_rdata;
            end
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Pipeline handshake outputs.
  assign stall_o = ((r_state == IDLE) & w_req) | (r_state == BUSY);
  assign done_o  = (r_state == DONE);
  assign data_o  = r_data;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Directed self-checking bench for dmem_responder.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dmem_responder;

  localparam int DEPTH_LOG2 = 10;
  localparam int LATENCY    = 3;

  logic        clk_i;
  logic        rst_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        stall_o;
  logic        done_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  dmem_responder #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .LATENCY    (LATENCY)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .MemRead_i  (MemRead_i),
    .MemWrite_i (MemWrite_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .stall_o    (stall_o),
    .done_o     (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one access from an IDLE negedge; returns at the DONE-cycle negedge
  // with requests released. Optionally disturbs addr/data during BUSY.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic scramble, input string tag,
                        output int start_cyc);
    int k;
    MemRead_i  = rd;
    MemWrite_i = wr;
    addr_i     = a;
    data_i     = d;
    #1;
    chk({tag, "_stall_c0"}, 32'(stall_o), 32'd1);
    start_cyc = cyc;
    k = 0;
    while (!done_o && k < 20) begin
      @(negedge clk_i);
      k++;
      if (scramble) begin
        addr_i = 32'h0000_0020;
        data_i = ~d;
      end
      if (!done_o) chk({tag, "_stall_busy"}, 32'(stall_o), 32'd1);
    end
    chk({tag, "_done_cycle"}, 32'(k), 32'(LATENCY + 1));
    chk({tag, "_stall_done"}, 32'(stall_o), 32'd0);
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
  endtask

  initial begin
    int s0, s1;
    rst_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0;
    addr_i = 32'h0; data_i = 32'h0;

    // 1. Reset held two cycles with a load request present
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      chk("rst_stall", 32'(stall_o), 32'd0);
      chk("rst_data",  data_o,       32'h0);
      chk("rst_done",  32'(done_o),  32'd0);
    end
    rst_i = 1'b0; MemRead_i = 1'b0;
    @(negedge clk_i);

    // 2. Preload word 5 through a store, then load it back
    access(1'b0, 1'b1, 32'h14, 32'hDEADBEEF, 1'b0, "pre_st", s0);
    chk("pre_mem5", dut.u_sram.memory[5], 32'hDEADBEEF);
    chk("pre_st_data", data_o, 32'h0);
    @(negedge clk_i);
    access(1'b1, 1'b0, 32'h14, 32'h0, 1'b0, "ld5", s0);
    chk("ld5_data", data_o, 32'hDEADBEEF);
    @(negedge clk_i);
    chk("ld5_hold", data_o, 32'hDEADBEEF);
    chk("idle_done", 32'(done_o), 32'd0);

    // 3. Store then load same word, back to back
    MemWrite_i = 1'b1; addr_i = 32'h20; data_i = 32'h12345678; MemRead_i = 1'b0;
    @(negedge clk_i);
    chk("st8_after_accept", dut.u_sram.memory[8], 32'h12345678);
    MemWrite_i = 1'b0;
    repeat (LATENCY) @(negedge clk_i);
    chk("st8_done", 32'(done_o), 32'd1);
    @(negedge clk_i);
    s0 = cyc - (LATENCY + 2);
    access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, "ld8", s1);
    chk("ld8_data", data_o, 32'h12345678);
    chk("pair_cycles", 32'(cyc - s0 + 1), 32'd10);
    @(negedge clk_i);

    // 4. Read+write together behaves as a store; data_o keeps prior value
    access(1'b0, 1'b1, 32'h4, 32'h1, 1'b0, "st1", s0);
    @(negedge clk_i);
    access(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, "ld1", s0);
    chk("ld1_data", data_o, 32'h1);
    @(negedge clk_i);
    access(1'b1, 1'b1, 32'h0, 32'hA5A5A5A5, 1'b0, "both", s0);
    chk("both_mem0", dut.u_sram.memory[0], 32'hA5A5A5A5);
    chk("both_data", data_o, 32'h1);
    @(negedge clk_i);

    // 5. Wrap and misalign: 0x1003 maps to word 0
    access(1'b1, 1'b0, 32'h0000_1003, 32'h0, 1'b0, "wrap", s0);
    chk("wrap_data", data_o, 32'hA5A5A5A5);
    @(negedge clk_i);

    // Inputs changing during BUSY are ignored
    access(1'b1, 1'b0, 32'h14, 32'h0, 1'b1, "scr", s0);
    chk("scr_data", data_o, 32'hDEADBEEF);
    @(negedge clk_i);

    // 6a. Reset in BUSY cycle 2 of a load drops it
    MemRead_i = 1'b1; addr_i = 32'h20;
    #1 chk("rl_stall_c0", 32'(stall_o), 32'd1);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1; MemRead_i = 1'b0;
    @(negedge clk_i);
    chk("rl_stall", 32'(stall_o), 32'd0);
    chk("rl_done",  32'(done_o),  32'd0);
    chk("rl_data",  data_o,       32'h0);
    rst_i = 1'b0;
    MemRead_i = 1'b1;
    #1 chk("rl_stall_req1", 32'(stall_o), 32'd1);
    MemRead_i = 1'b0;
    #1 chk("rl_stall_req0", 32'(stall_o), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      chk("rl_no_done", 32'(done_o), 32'd0);
    end

    // 6b. Reset mid-store keeps the already-written word
    MemWrite_i = 1'b1; addr_i = 32'h30; data_i = 32'hCAFEF00D;
    @(negedge clk_i);
    rst_i = 1'b1; MemWrite_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("rs_mem12", dut.u_sram.memory[12], 32'hCAFEF00D);
    chk("rs_stall", 32'(stall_o), 32'd0);
    @(negedge clk_i);
    access(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, "rs_ld", s0);
    chk("rs_ld_data", data_o, 32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
